ms_universal_shift_reg: RTL

//  Parametrised successor to the single-bit master-slave D flip-flop: a WIDTH-bit

---
 rtl/ms_universal_shift_reg.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ms_universal_shift_reg.sv
// ms_universal_shift_reg
//   WIDTH-bit edge-triggered universal shift register: hold, shift right,
//   shift left and parallel load, plus an auto-shift burst engine that
//   performs up to WIDTH single-position shifts, one per enabled cycle.
//
//   Build option:
//     ROTATE_EN  - when defined, every shift (mode-driven or burst) is a
//                  rotation and the serial inputs sin_r/sin_l are unused.
//                  When undefined, shifts fill from sin_r (at MSB) or
//                  sin_l (at LSB) and no rotation logic exists.
module ms_universal_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic                         sin_r,
    input  logic                         sin_l,
    input  logic                         start,
    input  logic [$clog2(WIDTH+1)-1:0]   amt,
    input  logic                         dir,
    output logic [WIDTH-1:0]             Q,
    output logic [WIDTH-1:0]             Qbar,
    output logic                         sout_r,
    output logic                         sout_l,
    output logic                         busy,
    output logic                         done
);

    localparam int CW = $clog2(WIDTH + 1);

    // Burst length ceiling and the terminal count value, sized to the counter.
    localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_CW   = CW'(1);
    localparam logic [CW-1:0] ZERO_CW  = '0;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cntNext;
    logic             dirLatched;
    logic             dirNext;
    logic [WIDTH-1:0] qReg;
    logic [WIDTH-1:0] qNext;
    logic             doneReg;
    logic             doneNext;

    // One position toward the LSB; the vacated MSB takes the fill bit.
    function automatic logic [WIDTH-1:0] shiftRight(input logic [WIDTH-1:0] q,
                                                    input logic             sIn);
`ifdef ROTATE_EN
        shiftRight = {q[0], q[WIDTH-1:1]};
`else
        shiftRight = {sIn, q[WIDTH-1:1]};
`endif
    endfunction

    // One position toward the MSB; the vacated LSB takes the fill bit.
    function automatic logic [WIDTH-1:0] shiftLeft(input logic [WIDTH-1:0] q,
                                                   input logic             sIn);
`ifdef ROTATE_EN
        shiftLeft = {q[WIDTH-2:0], q[WIDTH-1]};
`else
        shiftLeft = {q[WIDTH-2:0], sIn};
`endif
    endfunction

    // Requests longer than the register collapse to a full-width burst.
    function automatic logic [CW-1:0] clampAmt(input logic [CW-1:0] a);
        clampAmt = (a > WIDTH_CW) ? WIDTH_CW : a;
    endfunction

    // State, counter, latched direction, register contents and done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= ZERO_CW;
            dirLatched <= 1'b0;
            qReg       <= RST_VAL;
            doneReg    <= 1'b0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            dirLatched <= dirNext;
            qReg       <= qNext;
            doneReg    <= doneNext;
        end
    end

    // Next-state, burst bookkeeping and datapath select; en=0 holds everything
    // and leaves doneNext at its default of 0 so done drops on that edge.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        dirNext   = dirLatched;
        qNext     = qReg;
        doneNext  = 1'b0;

        if (en) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // A zero-length burst completes immediately without
                        // ever entering SHIFT; mode is ignored on any start.
                        if (amt == ZERO_CW) begin
                            doneNext = 1'b1;
                        end else begin
                            stateNext = SHIFT;
                            cntNext   = clampAmt(amt);
                            dirNext   = dir;
                        end
                    end else begin
                        unique case (mode)
                            MODE_HOLD:  qNext = qReg;
                            MODE_RIGHT: qNext = shiftRight(qReg, sin_r);
                            MODE_LEFT:  qNext = shiftLeft(qReg, sin_l);
                            MODE_LOAD:  qNext = d;
                            default:    qNext = qReg;
                        endcase
                    end
                end

                SHIFT: begin
                    // Serial inputs are sampled fresh on every burst step.
                    if (dirLatched) begin
                        qNext = shiftLeft(qReg, sin_l);
                    end else begin
                        qNext = shiftRight(qReg, sin_r);
                    end
                    cntNext = cnt - ONE_CW;
                    if (cnt == ONE_CW) begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                    end
                end

                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // Outputs are direct views of registered state.
    assign Q      = qReg;
    assign Qbar   = ~qReg;
    assign sout_r = qReg[0];
    assign sout_l = qReg[WIDTH-1];
    assign busy   = (state == SHIFT);
    assign done   = doneReg;

endmodule
